// File: rtl/adc_lvds_frame_aligner.sv
`default_nettype none
// ============================================================================
// Module   : adc_lvds_frame_aligner
// Function : Frame-lane driven BITSLIP word aligner for multi-lane LVDS ADCs,
//            with lock confirmation, loss-of-lock monitoring and bit reorder.
// Revision : 1.0 - initial release
// ============================================================================
module adc_lvds_frame_aligner #(
   parameter int          NCH       = 8,
   parameter int          WIDTH     = 14,
   parameter logic [13:0] FRAME_PAT = 14'b11111110000000,
   parameter int          SETTLE    = 3,
   parameter int          LOCK_CNT  = 16,
   parameter int          LOSS_CNT  = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                           CLKDIV,
   input  logic                           RST,
   input  logic                           EN,
   input  logic [WIDTH-1:0]               FRAME_Q,
   input  logic [NCH*WIDTH-1:0]           DATA_Q,
   output logic                           BITSLIP,
   output logic [NCH*WIDTH-1:0]           DATA_OUT,
   output logic                           DATA_VALID,
   output logic                           LOCKED,
   output logic                           ALIGN_ERR,
   output logic [$clog2(2*WIDTH+1)-1:0]   SLIP_COUNT
);

   localparam int c_SCW = $clog2(2*WIDTH+1);

   localparam logic [c_SCW-1:0] c_MAX_SLIP    = c_SCW'(2*WIDTH);
   localparam logic [7:0]       c_LOCK_LAST   = 8'(LOCK_CNT - 1);
   localparam logic [7:0]       c_LOSS_LAST   = 8'(LOSS_CNT - 1);
   localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE - 1);

   localparam logic [2:0] c_S_IDLE   = 3'd0;
   localparam logic [2:0] c_S_CHECK  = 3'd1;
   localparam logic [2:0] c_S_SLIP   = 3'd2;
   localparam logic [2:0] c_S_WAIT   = 3'd3;
   localparam logic [2:0] c_S_VERIFY = 3'd4;
   localparam logic [2:0] c_S_LOCKED = 3'd5;
   localparam logic [2:0] c_S_FAIL   = 3'd6;

   logic [2:0]           r_state;
   logic [c_SCW-1:0]     r_slip_cnt;
   logic [7:0]           r_match_cnt;
   logic [7:0]           r_miss_cnt;
   logic [3:0]           r_wait_cnt;
   logic                 r_bitslip;
   logic [NCH*WIDTH-1:0] r_data_out;
   logic                 r_data_valid;

   logic [2:0]           w_state_nx;
   logic [c_SCW-1:0]     w_slip_nx;
   logic [7:0]           w_match_nx;
   logic [7:0]           w_miss_nx;
   logic [3:0]           w_wait_nx;
   logic [WIDTH-1:0]     w_frame_ro;
   logic [NCH*WIDTH-1:0] w_data_ro;
   logic                 w_match;
   logic                 w_slip_exhausted;

   // Bit i of the reordered word comes from bit WIDTH-1-i when MSB_FIRST is set
   genvar gi, gn;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_frame_bit
         assign w_frame_ro[gi] = MSB_FIRST ? FRAME_Q[WIDTH-1-gi] : FRAME_Q[gi];
      end
      for (gn = 0; gn < NCH; gn++) begin : g_lane
         for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_data_ro[gn*WIDTH + gi] = MSB_FIRST ? DATA_Q[gn*WIDTH + WIDTH-1-gi]
                                                        : DATA_Q[gn*WIDTH + gi];
         end
      end
   endgenerate

   assign w_match          = (w_frame_ro == FRAME_PAT[WIDTH-1:0]);
   assign w_slip_exhausted = (r_slip_cnt == c_MAX_SLIP);

   always_comb begin
      w_state_nx = r_state;
      w_slip_nx  = r_slip_cnt;
      w_match_nx = r_match_cnt;
      w_miss_nx  = r_miss_cnt;
      w_wait_nx  = r_wait_cnt;
      if (!EN) begin
         w_state_nx = c_S_IDLE;
         w_slip_nx  = '0;
         w_match_nx = '0;
         w_miss_nx  = '0;
         w_wait_nx  = '0;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               w_slip_nx  = '0;
               w_match_nx = '0;
               w_miss_nx  = '0;
               w_wait_nx  = '0;
               w_state_nx = c_S_CHECK;
            end
            c_S_CHECK: begin
               if (w_match) begin
                  w_match_nx = 8'd1;
                  w_state_nx = c_S_VERIFY;
               end else begin
                  w_state_nx = w_slip_exhausted ? c_S_FAIL : c_S_SLIP;
               end
            end
            c_S_SLIP: begin
               if (!w_slip_exhausted) begin
                  w_slip_nx = r_slip_cnt + 1'b1;
               end
               w_wait_nx  = '0;
               w_state_nx = c_S_WAIT;
            end
            c_S_WAIT: begin
               if (r_wait_cnt == c_SETTLE_LAST) begin
                  w_wait_nx  = '0;
                  w_state_nx = c_S_CHECK;
               end else begin
                  w_wait_nx = r_wait_cnt + 1'b1;
               end
            end
            c_S_VERIFY: begin
               if (w_match) begin
                  w_match_nx = r_match_cnt + 1'b1;
                  if (r_match_cnt == c_LOCK_LAST) begin
                     w_miss_nx  = '0;
                     w_state_nx = c_S_LOCKED;
                  end
               end else begin
                  w_match_nx = '0;
                  w_state_nx = w_slip_exhausted ? c_S_FAIL : c_S_SLIP;
               end
            end
            c_S_LOCKED: begin
               if (w_match) begin
                  w_miss_nx = '0;
               end else if (r_miss_cnt == c_LOSS_LAST) begin
                  // Lock lost: a fresh search starts with a clean slip budget
                  w_miss_nx  = '0;
                  w_slip_nx  = '0;
                  w_match_nx = '0;
                  w_state_nx = c_S_CHECK;
               end else begin
                  w_miss_nx = r_miss_cnt + 1'b1;
               end
            end
            c_S_FAIL: begin
               w_state_nx = c_S_FAIL;
            end
            default: begin
               w_state_nx = c_S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLKDIV) begin
      if (RST) begin
         r_state      <= c_S_IDLE;
         r_slip_cnt   <= '0;
         r_match_cnt  <= '0;
         r_miss_cnt   <= '0;
         r_wait_cnt   <= '0;
         r_bitslip    <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_slip_cnt   <= w_slip_nx;
         r_match_cnt  <= w_match_nx;
         r_miss_cnt   <= w_miss_nx;
         r_wait_cnt   <= w_wait_nx;
         // Registered so the pulse is high exactly during the SLIP-state cycle
         r_bitslip    <= (w_state_nx == c_S_SLIP);
         r_data_out   <= w_data_ro;
         r_data_valid <= (r_state == c_S_LOCKED);
      end
   end

   assign BITSLIP    = r_bitslip;
   assign DATA_OUT   = r_data_out;
   assign DATA_VALID = r_data_valid;
   assign LOCKED     = (r_state == c_S_LOCKED);
   assign ALIGN_ERR  = (r_state == c_S_FAIL);
   assign SLIP_COUNT = r_slip_cnt;

endmodule
`default_nettype wire
